prt_dptx_sdp_sched: RTL and testbench
=====================================

// Module: prt_dptx_sdp_sched
// PURPOSE
//  Schedules SDP insertion in the DPTX vertical blanking window. Multiple SDP
//  sources (AE, VSC, infoframe, ...) raise requests with a payload. Block
//  arbitrates them round-robin and streams each winner to the link SDP port
//  via valid/ready. Sits between the SDP generators and the DPTX link mux.
// PARAMETERS
//  NUM_REQ       4    number of requesters (2..8)
//  PAYLOAD_W     128  SDP payload width, bits
//  MAX_PER_BLANK 2    max SDPs sent per vblank window (1..15)
// PORTS
//  clk          in   1                  system clock; single clock domain
//  rst_n        in   1                  asynchronous reset, active-low
//  en           in   1                  scheduler enable
//  vsync        in   1                  vblank indicator, high = window open
//  req_valid    in   NUM_REQ            per-source request, held until granted
//  req_payload  in   NUM_REQ*PAYLOAD_W  source i at [i*PAYLOAD_W +: PAYLOAD_W]
//  req_grant    out  NUM_REQ            one-hot, 1-cycle capture pulse
//  sdp_valid    out  1                  SDP on sdp_payload is valid
//  sdp_ready    in   1                  link accepts SDP this cycle
//  sdp_payload  out  PAYLOAD_W          selected SDP payload
//  sdp_src      out  $clog2(NUM_REQ)    index of source in sdp_payload
//  miss_cnt     out  16                 missed-window counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (sdp_valid, req_grant, sdp_payload,
//   sdp_src, miss_cnt); rr_ptr=0; sent count=0. Reset mid-packet drops the SDP.
//  vsync is registered once (vs_d). Window opens on vsync & !vs_d.
//  FSM:
//   IDLE  : window open & en -> ARB; sent cnt cleared.
//   ARB   : !vsync -> IDLE. Else pick the first i with req_valid[i], searching
//           rr_ptr, rr_ptr+1, .. mod NUM_REQ. If found: capture payload and
//           index -> SEND. Next cycle: sdp_valid=1, req_grant[i]=1 for exactly
//           that cycle. No request -> stay in ARB.
//   SEND  : hold sdp_valid, sdp_payload, sdp_src stable until sdp_valid &
//           sdp_ready. On transfer: sdp_valid=0 next cycle; sent++;
//           rr_ptr=(i+1) mod NUM_REQ. Then if sent==MAX_PER_BLANK -> HOLD;
//           if !vsync or !en -> IDLE; else -> ARB.
//   HOLD  : wait for !vsync -> IDLE. No grants.
//  Latency: request seen in ARB at cycle N -> sdp_valid/req_grant at N+1.
//   Minimum 2 cycles per SDP with sdp_ready held high.
//  vsync falls during SEND: the current SDP completes; no further arbitration.
//   vsync falls in ARB: no capture that cycle.
//  en deassert: blocks entry to ARB/new captures; SEND in flight completes.
//  Requester drops req_valid before grant: legal; no capture if not yet
//   selected. Payload read only in the ARB capture cycle.
//  Never more than MAX_PER_BLANK transfers per window. At most one req_grant
//   bit set. rr_ptr persists across windows.
// CONFIGURATION
//  SDP_SCHED_STATS_EN defined: miss_cnt (16-bit, saturating at 16'hFFFF)
//   increments once per window that closes (vsync falling seen by FSM in
//   ARB/HOLD/SEND) while any req_valid bit is still high and ungranted.
//  Not defined: miss_cnt tied to 16'h0000; no counter logic.
// TESTING
//  1 Reset: rst_n=0 mid-SEND -> sdp_valid=0, req_grant=0, miss_cnt=0
//    immediately; first SDP after release only in a new window.
//  2 NUM_REQ=4, req_valid=4'b1111, sdp_ready=1, one long window,
//    MAX_PER_BLANK=2 -> grants 0,1; next window grants 2,3; then 0,1.
//  3 Backpressure: sdp_ready=0 for 5 cycles after sdp_valid -> payload and
//    sdp_src stable; one transfer on the cycle sdp_ready=1.
//  4 vsync falls 1 cycle after sdp_valid, sdp_ready late -> that SDP completes;
//    no second grant; FSM returns to IDLE.
//  5 en=0 with req_valid=4'b0100 across window -> zero grants; with
//    SDP_SCHED_STATS_EN miss_cnt 0->1; without it miss_cnt stays 0.
//  6 Only req_valid[3] set, rr_ptr=1 -> grant 4'b1000, sdp_src=3, rr_ptr->0.

Source files
------------

// File: rtl/prt_dptx_sdp_sched.sv
// Round-robin SDP scheduler for the DPTX vblank window. `SDP_SCHED_STATS_EN enables the miss_cnt statistic.
// Latency: request captured in ARB at cycle N -> sdp_valid/req_grant at N+1; at least 2 cycles per SDP.
// Backpressure: sdp_valid/payload/src held until sdp_ready; at most MAX_PER_BLANK SDPs per window.
module prt_dptx_sdp_sched #(
   parameter int NUM_REQ       = 4,
   parameter int PAYLOAD_W     = 128,
   parameter int MAX_PER_BLANK = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         vsync,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
   output logic [NUM_REQ-1:0]           req_grant,
   output logic                         sdp_valid,
   input  logic                         sdp_ready,
   output logic [PAYLOAD_W-1:0]         sdp_payload,
   output logic [$clog2(NUM_REQ)-1:0]   sdp_src,
   output logic [15:0]                  miss_cnt
);

   localparam int SRC_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, ARB, SEND, HOLD} state_t;

   state_t               state, state_nxt;
   logic                 vs_d;
   logic [SRC_W-1:0]     rr_ptr;
   logic [3:0]           sent;
   logic                 win_open, capture, xfer, found;
   logic [SRC_W-1:0]     pick;
   logic [PAYLOAD_W-1:0] pay_arr [NUM_REQ];

   assign win_open  = vsync & ~vs_d;
   assign sdp_valid = (state == SEND);
   assign xfer      = sdp_valid & sdp_ready;
   assign capture   = (state == ARB) & vsync & en & found;

   always_comb begin : pay_split
      for (int i = 0; i < NUM_REQ; i++) begin
         pay_arr[i] = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
   end

   always_comb begin : rr_search
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[SRC_W'(idx)]) begin
            found = 1'b1;
            pick  = SRC_W'(idx);
         end
      end
   end

   always_comb begin : fsm_next
      state_nxt = state;
      case (state)
         IDLE: if (win_open && en) state_nxt = ARB;
         ARB: begin
            if (!vsync) state_nxt = IDLE;
            else if (capture) state_nxt = SEND;
         end
         SEND: begin
            if (sdp_ready) begin
               if (sent == 4'(MAX_PER_BLANK - 1)) state_nxt = HOLD;
               else if (!vsync || !en) state_nxt = IDLE;
               else state_nxt = ARB;
            end
         end
         HOLD: if (!vsync) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // vs_d resets high so a window already open at reset release is not taken as a new one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         vs_d        <= 1'b1;
         rr_ptr      <= '0;
         sent        <= '0;
         req_grant   <= '0;
         sdp_payload <= '0;
         sdp_src     <= '0;
      end else begin
         state     <= state_nxt;
         vs_d      <= vsync;
         req_grant <= '0;
         if (state == IDLE && state_nxt == ARB) sent <= '0;
         if (capture) begin
            req_grant   <= NUM_REQ'(1) << pick;
            sdp_payload <= pay_arr[pick];
            sdp_src     <= pick;
         end
         if (xfer) begin
            sent   <= sent + 1'b1;
            rr_ptr <= (sdp_src == SRC_W'(NUM_REQ - 1)) ? '0 : sdp_src + 1'b1;
         end
      end
   end

`ifdef SDP_SCHED_STATS_EN
   logic closing;

   // A request still waiting when the FSM sees the window close is one missed window.
   assign closing = vs_d & ~vsync & (state != IDLE) & (|(req_valid & ~req_grant));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_cnt <= '0;
      end else if (closing && miss_cnt != 16'hFFFF) begin
         miss_cnt <= miss_cnt + 16'd1;
      end
   end
`else
   assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_prt_dptx_sdp_sched.sv
// Bench for prt_dptx_sdp_sched: transaction-level round-robin model checked every cycle,
// plus directed windows with literal expected grant sequences.
module tb_prt_dptx_sdp_sched;

   localparam int NUM_REQ = 4;
   localparam int MAX_PER_BLANK = 2;
`ifdef SDP_SCHED_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         vsync;
   logic [3:0]   req_valid;
   logic [511:0] req_payload;
   logic [3:0]   req_grant;
   logic         sdp_valid;
   logic         sdp_ready;
   logic [127:0] sdp_payload;
   logic [1:0]   sdp_src;
   logic [15:0]  miss_cnt;

   int n_checks = 0;
   int n_fail = 0;

   bit           p_valid, p_ready, p_vs, p_en;
   logic [3:0]   p_req;
   logic [1:0]   p_src;
   logic [127:0] p_pay;
   int           m_ptr, g_cnt;
   int           grant_log[$];
   int           xfer_log[$];
   logic [3:0]   gvec_log[$];

   prt_dptx_sdp_sched #(.NUM_REQ(4), .PAYLOAD_W(128), .MAX_PER_BLANK(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .vsync(vsync),
      .req_valid(req_valid), .req_payload(req_payload), .req_grant(req_grant),
      .sdp_valid(sdp_valid), .sdp_ready(sdp_ready), .sdp_payload(sdp_payload),
      .sdp_src(sdp_src), .miss_cnt(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] pay(input int i);
      logic [31:0] v;
      v = 32'(i);
      return {32'hA1000000 | v, 32'hB2000000 | v, 32'hC3000000 | v, 32'hD4000000 | v};
   endfunction

   function automatic int rr_pick(input logic [3:0] req, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic int glog(input int i);
      return (i < grant_log.size()) ? grant_log[i] : -1;
   endfunction

   function automatic int xlog(input int i);
      return (i < xfer_log.size()) ? xfer_log[i] : -1;
   endfunction

   function automatic logic [3:0] gvec(input int i);
      return (i < gvec_log.size()) ? gvec_log[i] : 4'bxxxx;
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      xfer_log.delete();
      gvec_log.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_grants(input int n, input string name);
      int k;
      k = 0;
      while (grant_log.size() < n && k < 200) begin
         tick(1);
         k++;
      end
      check(name, grant_log.size(), n);
   endtask

   // Runs at every falling edge; inputs seen here are the ones the next rising edge samples.
   task automatic mon_step();
      int exp_src;
      if (!rst_n) begin
         p_valid = 0; p_ready = 0; p_vs = 0; p_en = 0; p_req = '0;
         m_ptr = 0; g_cnt = 0;
         return;
      end
      if (p_valid && p_ready) begin
         check("valid_drop_after_xfer", sdp_valid, 1'b0);
         xfer_log.push_back(int'(p_src));
         m_ptr = (int'(p_src) + 1) % NUM_REQ;
      end
      if (p_valid && !p_ready)
         check("hold_stable", {sdp_valid, sdp_src, sdp_payload}, {1'b1, p_src, p_pay});
      check("grant_iff_new_sdp", |req_grant, sdp_valid && !p_valid);
      if (!p_vs) g_cnt = 0;
      if (|req_grant) begin
         exp_src = rr_pick(p_req, m_ptr);
         check("grant_onehot", req_grant, 4'd1 << sdp_src);
         check("rr_winner", sdp_src, exp_src);
         check("capture_gate", {p_vs, p_en}, 2'b11);
         check("payload", sdp_payload, pay(int'(sdp_src)));
         check("max_per_blank", g_cnt < MAX_PER_BLANK, 1'b1);
         g_cnt++;
         grant_log.push_back(int'(sdp_src));
         gvec_log.push_back(req_grant);
      end
      p_valid = sdp_valid; p_ready = sdp_ready; p_src = sdp_src; p_pay = sdp_payload;
      p_req = req_valid; p_vs = vsync; p_en = en;
   endtask

   initial begin
      int exp2[6] = '{0, 1, 2, 3, 0, 1};
      rst_n = 1'b0; en = 1'b0; vsync = 1'b0; req_valid = '0; sdp_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) req_payload[i*128 +: 128] = pay(i);
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
      join_none
      tick(3);

      // Reset values, then an asynchronous reset in the middle of a SEND
      check("rst_valid", sdp_valid, 1'b0);
      check("rst_grant", req_grant, 4'b0000);
      check("rst_payload", sdp_payload, 128'h0);
      check("rst_src", sdp_src, 2'd0);
      check("rst_miss", miss_cnt, 16'h0000);
      rst_n = 1'b1;
      tick(2);
      en = 1'b1; req_valid = 4'b0010; sdp_ready = 1'b0; vsync = 1'b1;
      wait_grants(1, "t1_grant");
      check("t1_in_send", sdp_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t1_rst_valid", sdp_valid, 1'b0);
      check("t1_rst_grant", req_grant, 4'b0000);
      check("t1_rst_miss", miss_cnt, 16'h0000);
      tick(2);
      rst_n = 1'b1;
      clear_logs();
      sdp_ready = 1'b1;
      tick(10);
      check("t1_no_grant_same_window", grant_log.size(), 0);
      vsync = 1'b0;
      tick(3);
      vsync = 1'b1;
      wait_grants(1, "t1_new_window");
      check("t1_src", glog(0), 1);
      req_valid = '0;
      tick(3);
      vsync = 1'b0;
      tick(3);

      // Three windows with all four sources requesting
      do_reset();
      clear_logs();
      req_valid = 4'b1111; sdp_ready = 1'b1; en = 1'b1;
      repeat (3) begin
         vsync = 1'b1;
         tick(20);
         vsync = 1'b0;
         tick(4);
      end
      check("t2_count", xfer_log.size(), 6);
      for (int i = 0; i < 6; i++) check($sformatf("t2_xfer%0d", i), xlog(i), exp2[i]);
      req_valid = '0;

      // Backpressure: ready low for five cycles after sdp_valid
      do_reset();
      clear_logs();
      req_valid = 4'b0001; sdp_ready = 1'b0; vsync = 1'b1;
      wait_grants(1, "t3_grant");
      req_valid = '0;
      tick(4);
      check("t3_no_xfer", xfer_log.size(), 0);
      check("t3_held", {sdp_valid, sdp_src, sdp_payload}, {1'b1, 2'd0, pay(0)});
      sdp_ready = 1'b1;
      tick(1);
      check("t3_valid_low", sdp_valid, 1'b0);
      tick(6);
      check("t3_one_xfer", xfer_log.size(), 1);
      check("t3_xfer_src", xlog(0), 0);
      vsync = 1'b0;
      tick(3);

      // vsync falls while an SDP waits for ready
      do_reset();
      clear_logs();
      req_valid = 4'b0011; sdp_ready = 1'b0; vsync = 1'b1;
      wait_grants(1, "t4_grant");
      req_valid = 4'b0010; vsync = 1'b0;
      tick(3);
      sdp_ready = 1'b1;
      tick(10);
      check("t4_xfers", xfer_log.size(), 1);
      check("t4_grants", grant_log.size(), 1);
      check("t4_src", xlog(0), 0);
      check("t4_miss", miss_cnt, 16'(STATS));
      vsync = 1'b1;
      wait_grants(2, "t4_reopen");
      check("t4_reopen_src", glog(1), 1);
      req_valid = '0;
      tick(3);
      vsync = 1'b0;
      tick(3);

      // en dropped as the window opens, then a whole window with en low
      do_reset();
      clear_logs();
      check("t5_miss_start", miss_cnt, 16'h0000);
      req_valid = 4'b0100; sdp_ready = 1'b1; en = 1'b1; vsync = 1'b1;
      tick(1);
      en = 1'b0;
      tick(12);
      vsync = 1'b0;
      tick(3);
      check("t5_grants", grant_log.size(), 0);
      check("t5_miss", miss_cnt, 16'(STATS));
      vsync = 1'b1;
      tick(12);
      vsync = 1'b0;
      tick(3);
      check("t5_grants_idle", grant_log.size(), 0);
      check("t5_miss_idle", miss_cnt, 16'(STATS));
      req_valid = '0; en = 1'b1;

      // Only source 3 requesting with the pointer at 1, then wrap to 0
      do_reset();
      clear_logs();
      req_valid = 4'b0001; vsync = 1'b1;
      wait_grants(1, "t6_pre");
      req_valid = '0;
      tick(3);
      vsync = 1'b0;
      tick(3);
      req_valid = 4'b1000; vsync = 1'b1;
      wait_grants(2, "t6_grant");
      req_valid = '0;
      check("t6_vec", gvec(1), 4'b1000);
      check("t6_src", glog(1), 3);
      tick(3);
      vsync = 1'b0;
      tick(3);
      req_valid = 4'b1001; vsync = 1'b1;
      wait_grants(3, "t6_wrap");
      check("t6_wrap_src", glog(2), 0);
      tick(8);
      vsync = 1'b0;
      req_valid = '0;
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
